// File: rtl/btb_ctrl_pkg.sv
// Shared types and default sizes for the branch target buffer.
package btb_ctrl_pkg;

  localparam int BTB_INDEX_W = 3;
  localparam int BTB_TAG_W   = 6;

  typedef struct packed {
    logic                 v;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          ta;
    logic                 t;
  } cache_branch_t;

  typedef enum logic {
    SWEEP,
    RUN
  } btb_state_t;

endpackage

// File: rtl/btb_array.sv
// BTB storage: 2**INDEX_W entries, asynchronous reads, one synchronous write port.
// Latency: reads combinational, writes visible the cycle after the write edge.
// Backpressure: none; the controller owns the write port and never stalls it.
module btb_array
  import btb_ctrl_pkg::*;
#(
  parameter int INDEX_W = BTB_INDEX_W
) (
  input  logic               clk,
  input  logic               we,
  input  logic [INDEX_W-1:0] wa,
  input  cache_branch_t      wd,
  input  logic [INDEX_W-1:0] ra0,
  output cache_branch_t      rd0,
  input  logic [INDEX_W-1:0] ra1,
  output cache_branch_t      rd1
);

  // Storage is not reset; the controller sweep clears the valid bits.
  cache_branch_t mem [2**INDEX_W];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Port 0 serves fetch lookups, port 1 the read-modify-write of a not-taken update.
  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/btb_ctrl.sv
// BTB controller: combinational fetch lookup, EX update port, init/flush sweep.
// Latency: lookup 0 cycles; an accepted update becomes visible 2 cycles after accept.
// Backpressure: upd_ready drops only while a sweep runs with the pending slot full.
module btb_ctrl
  import btb_ctrl_pkg::*;
#(
  parameter int INDEX_W = BTB_INDEX_W,
  parameter int TAG_W   = BTB_TAG_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        busy,
  input  logic        flush_req,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int DEPTH = 2**INDEX_W;

  btb_state_t         state;
  logic [INDEX_W-1:0] sweep_idx;
  logic               pend_valid;
  logic [INDEX_W-1:0] pend_idx;
  logic [TAG_W-1:0]   pend_tag;
  logic               pend_taken;
  logic [31:0]        pend_target;

  logic [INDEX_W-1:0] lu_idx;
  logic [TAG_W-1:0]   lu_tag;
  cache_branch_t      lu_entry;
  cache_branch_t      pend_entry;
  logic               upd_acc;

  logic               we;
  logic [INDEX_W-1:0] wa;
  cache_branch_t      wd;

  assign lu_idx = if_pc[INDEX_W+1:2];
  assign lu_tag = if_pc[INDEX_W+TAG_W+1:INDEX_W+2];

  // Only index and tag bits participate; alignment and high PC bits are don't-care.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[31:INDEX_W+TAG_W+2], if_pc[1:0],
                            upd_pc[31:INDEX_W+TAG_W+2], upd_pc[1:0]};

  btb_array #(.INDEX_W(INDEX_W)) u_array (
    .clk (clk),
    .we  (we),
    .wa  (wa),
    .wd  (wd),
    .ra0 (lu_idx),
    .rd0 (lu_entry),
    .ra1 (pend_idx),
    .rd1 (pend_entry)
  );

  assign busy        = rst | (state == SWEEP);
  assign upd_ready   = rst | (state == RUN) | ~pend_valid;
  assign upd_acc     = upd_valid & upd_ready;
  assign pred_hit    = ~busy & lu_entry.v & (lu_entry.tag == lu_tag);
  assign pred_taken  = pred_hit & lu_entry.t;
  assign pred_target = pred_taken ? lu_entry.ta : 32'h0;

  // Sweep owns the write port; otherwise the pending update drains under the write policy.
  always_comb begin
    we = 1'b0;
    wa = sweep_idx;
    wd = '0;
    if (state == SWEEP) begin
      we = 1'b1;
    end else if (pend_valid) begin
      wa = pend_idx;
      if (pend_taken) begin
        we = 1'b1;
        wd = '{v: 1'b1, tag: pend_tag, ta: pend_target, t: 1'b1};
      end else if (pend_entry.v && (pend_entry.tag == pend_tag)) begin
        we   = 1'b1;
        wd   = pend_entry;
        wd.t = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SWEEP;
      sweep_idx  <= '0;
      pend_valid <= 1'b0;
    end else begin
      case (state)
        SWEEP: begin
          sweep_idx <= sweep_idx + INDEX_W'(1);
          if (sweep_idx == INDEX_W'(DEPTH-1)) state <= RUN;
        end
        RUN: begin
          if (flush_req) begin
            state     <= SWEEP;
            sweep_idx <= '0;
          end
        end
        default: state <= SWEEP;
      endcase
      if (upd_acc)           pend_valid <= 1'b1;
      else if (state == RUN) pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (upd_acc) begin
      pend_idx    <= upd_pc[INDEX_W+1:2];
      pend_tag    <= upd_pc[INDEX_W+TAG_W+1:INDEX_W+2];
      pend_taken  <= upd_taken;
      pend_target <= upd_target;
    end
  end

endmodule

// File: tb/tb_btb_ctrl.sv
// Bench for btb_ctrl: directed scenarios plus random traffic against a table-level model.
module tb_btb_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush_req, upd_valid, upd_taken;
  logic [31:0] if_pc, upd_pc, upd_target;
  logic        pred_hit, pred_taken, busy, upd_ready;
  logic [31:0] pred_target;

  always #5 clk = ~clk;

  btb_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .if_pc       (if_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .busy        (busy),
    .flush_req   (flush_req),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: whole-table view, a sweep countdown and a pending-update queue.
  typedef struct {
    logic [31:0] pc;
    bit          taken;
    logic [31:0] tgt;
  } upd_s;

  bit          m_v   [8];
  int unsigned m_tag [8];
  logic [31:0] m_ta  [8];
  bit          m_t   [8];
  int          sweep_left = 8;
  upd_s        pq[$];

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) % 8;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc >> 5) % 64;
  endfunction

  function automatic void clear_table();
    for (int i = 0; i < 8; i++) m_v[i] = 1'b0;
  endfunction

  function automatic bit m_busy();
    return rst || (sweep_left > 0);
  endfunction

  function automatic bit m_ready();
    return rst || (sweep_left == 0) || (pq.size() == 0);
  endfunction

  function automatic bit m_hit();
    int unsigned i = idx_of(if_pc);
    return !m_busy() && m_v[i] && (m_tag[i] == tag_of(if_pc));
  endfunction

  function automatic bit m_taken();
    return m_hit() && m_t[idx_of(if_pc)];
  endfunction

  function automatic logic [31:0] m_target();
    return m_taken() ? m_ta[idx_of(if_pc)] : 32'h0;
  endfunction

  function automatic void apply_upd(input upd_s u);
    int unsigned i = idx_of(u.pc);
    if (u.taken) begin
      m_v[i]   = 1'b1;
      m_tag[i] = tag_of(u.pc);
      m_ta[i]  = u.tgt;
      m_t[i]   = 1'b1;
    end else if (m_v[i] && m_tag[i] == tag_of(u.pc)) begin
      m_t[i] = 1'b0;
    end
  endfunction

  initial clear_table();

  always @(posedge clk) begin
    bit   acc;
    upd_s u;
    acc = upd_valid && m_ready();
    if (rst) begin
      clear_table();
      sweep_left = 8;
      pq.delete();
    end else begin
      if (sweep_left > 0) begin
        sweep_left--;
      end else begin
        if (pq.size() > 0) apply_upd(pq.pop_front());
        if (flush_req) begin
          clear_table();
          sweep_left = 8;
        end
      end
      if (acc) begin
        u.pc = upd_pc; u.taken = upd_taken; u.tgt = upd_target;
        pq.push_back(u);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy());
      chk("upd_ready", upd_ready, m_ready());
      chk("pred_hit", pred_hit, m_hit());
      chk("pred_taken", pred_taken, m_taken());
      chk("pred_target", pred_target, m_target());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic do_upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    tick();
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    tick();
    upd_valid = 1'b0;
    tick();
  endtask

  task automatic look(input string nm, input logic [31:0] pc, input bit eh, input bit et,
                      input logic [31:0] etgt);
    tick();
    if_pc = pc;
    @(negedge clk);
    chk({nm, "_hit"}, pred_hit, eh);
    chk({nm, "_taken"}, pred_taken, et);
    chk({nm, "_target"}, pred_target, etgt);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = $urandom & 32'hFFFF_F800;
    p = p | (32'($urandom_range(0, 3)) << 5);
    p = p | (32'($urandom_range(0, 7)) << 2);
    p = p | 32'($urandom_range(0, 3));
    return p;
  endfunction

  initial begin
    int n;
    rst = 1'b1; flush_req = 1'b0; upd_valid = 1'b0;
    upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    if_pc = 32'h0040_0060;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_ready", upd_ready, 1);
    chk("rst_hit", pred_hit, 0);
    chk("rst_target", pred_target, 0);

    // Reset release: exactly 8 busy cycles, no hit anywhere
    tick();
    rst = 1'b0;
    wait_sweep(n);
    chk("t1_busy_len", n, 8);
    chk("t1_hit_after", pred_hit, 0);

    // Taken update: miss at t+1, hit at t+2
    tick();
    upd_valid = 1'b1; upd_pc = 32'h0040_0060; upd_taken = 1'b1; upd_target = 32'h0040_008C;
    tick();
    upd_valid = 1'b0;
    @(negedge clk);
    chk("t2_miss_t1", pred_hit, 0);
    tick();
    @(negedge clk);
    chk("t2_hit_t2", pred_hit, 1);
    chk("t2_taken_t2", pred_taken, 1);
    chk("t2_target_t2", pred_target, 32'h0040_008C);

    // Not-taken on a hit clears T only; not-taken on an alias miss is dropped
    do_upd(32'h0040_0060, 1'b0, 32'h1234_5678);
    look("t3a", 32'h0040_0060, 1, 0, 0);
    do_upd(32'h0040_0080, 1'b0, 32'h0000_0400);
    look("t3b", 32'h0040_0060, 1, 0, 0);
    look("t3c", 32'h0040_0080, 0, 0, 0);

    // Taken alias replaces the entry
    do_upd(32'h0040_0080, 1'b1, 32'h0040_0070);
    look("t4a", 32'h0040_0060, 0, 0, 0);
    look("t4b", 32'h0040_0080, 1, 1, 32'h0040_0070);

    // Flush with a simultaneous accept: held across the sweep, then written
    tick();
    flush_req = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h0040_0064; upd_taken = 1'b1; upd_target = 32'h0040_001C;
    @(negedge clk);
    chk("t5_ready_flush", upd_ready, 1);
    tick();
    flush_req = 1'b0; upd_valid = 1'b0;
    @(negedge clk);
    chk("t5_ready_held", upd_ready, 0);
    chk("t5_busy", busy, 1);
    wait_sweep(n);
    chk("t5_busy_len", n + 1, 8);
    look("t5a", 32'h0040_0064, 1, 1, 32'h0040_001C);
    look("t5b", 32'h0040_0060, 0, 0, 0);
    look("t5c", 32'h0040_0080, 0, 0, 0);

    // Reset mid-sweep with a held update: sweep restarts and the update is lost
    tick();
    flush_req = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h0040_0068; upd_taken = 1'b1; upd_target = 32'h0040_0200;
    tick();
    flush_req = 1'b0; upd_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_sweep(n);
    chk("t6_busy_len", n, 8);
    tick();
    look("t6a", 32'h0040_0068, 0, 0, 0);
    look("t6b", 32'h0040_0064, 0, 0, 0);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst        = ($urandom_range(0, 299) == 0);
      flush_req  = ($urandom_range(0, 39) == 0);
      upd_valid  = $urandom_range(0, 1);
      upd_pc     = rand_pc();
      upd_taken  = $urandom_range(0, 1);
      upd_target = $urandom;
      if_pc      = rand_pc();
    end
    tick();
    rst = 1'b0; flush_req = 1'b0; upd_valid = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
